// File: rtl/frame_buffer_dbl.sv
`default_nettype none
// frame_buffer_dbl: two-page frame store with a vsync-committed page flip and a back-page clear engine.
// Build macro FB_TRANSPARENT_EN: accepted user writes equal to TRANSP_VAL are colour-keyed out.
module frame_buffer_dbl #(
    parameter int                H_RES     = 640,
    parameter int                V_RES     = 480,
    parameter int                PIX_W     = 4,
    parameter logic [PIX_W-1:0]  CLEAR_VAL = '0,
`ifdef FB_TRANSPARENT_EN
    parameter logic [PIX_W-1:0]  TRANSP_VAL = {PIX_W{1'b1}},
`endif
    parameter int                DEPTH     = H_RES * V_RES,
    parameter int                ADDR_W    = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset_h,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    input  logic              swap_req,
    input  logic              vsync,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              swap_pending,
    output logic              front_page
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IX = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic              front_q, front_d;
    logic              pend_q, pend_d;
    logic              tgt_q, tgt_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_ok_q;
    logic [PIX_W-1:0]  ram_q;

    logic              commit;
    logic              wr_hit;
    logic              mem_we;
    logic [ADDR_W:0]   mem_waddr;
    logic [PIX_W-1:0]  mem_wdata;

    // Each page is padded to a power of two so {page, index} is a plain concatenation.
    logic [PIX_W-1:0]  mem [0:(2**(ADDR_W+1))-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        mem_we    = 1'b0;
        mem_waddr = {~front_q, wr_addr};
        mem_wdata = wr_data;

        commit  = vsync && (pend_q || swap_req) && (state_q == S_IDLE);
        front_d = front_q ^ commit;
        pend_d  = commit ? 1'b0 : (pend_q | swap_req);

        wr_hit = we && ({1'b0, wr_addr} < DEPTH_W);
`ifdef FB_TRANSPARENT_EN
        if (wr_data == TRANSP_VAL) begin
            wr_hit = 1'b0;
        end
`endif

        case (state_q)
            S_IDLE: begin
                mem_we = wr_hit;
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    // A flip on this same edge makes the outgoing front page the new back page.
                    tgt_d   = commit ? front_q : ~front_q;
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = {tgt_q, cnt_q};
                mem_wdata = CLEAR_VAL;
                if (cnt_q == LAST_IX) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            state_q <= S_IDLE;
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            tgt_q   <= 1'b0;
            cnt_q   <= '0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            rd_ok_q <= ({1'b0, rd_addr} < DEPTH_W);
        end
    end

    // Storage kept free of reset so it maps onto a simple-dual-port block RAM.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        ram_q <= mem[{front_q, rd_addr}];
    end

    assign rd_data      = rd_ok_q ? ram_q : '0;
    assign wr_ready     = (state_q == S_IDLE);
    assign clear_busy   = (state_q == S_CLEAR);
    assign swap_pending = pend_q;
    assign front_page   = front_q;

endmodule
`default_nettype wire
